// File: rtl/barrel_move.sv
// barrel_move: per-barrel motion engine. Spawns on start, rolls along each
// level, drops at the level edge, and repeats for LEVELS levels. It pulses
// done for one cycle when the barrel leaves the bottom level.
// Optional feature macro: BARREL_GRAVITY_EN. When it is defined, the fall
// accelerates from 1 px/tick up to V_MAX. When it is undefined, the barrel
// falls at a constant V_STEP px/tick.
module barrel_move #(
    parameter int X_START = 100,
    parameter int Y_START = 160,
    parameter int X_MIN   = 32,
    parameter int X_MAX   = 960,
    parameter int LEVEL_H = 96,
    parameter int LEVELS  = 5,
    parameter int H_STEP  = 2,
    parameter int V_STEP  = 4,
    parameter int V_MAX   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        clear,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        active,
    output logic        dir,
    output logic        done
);

    localparam logic [10:0] XS_C  = 11'(X_START);
    localparam logic [10:0] YS_C  = 11'(Y_START);
    localparam logic [10:0] XMN_C = 11'(X_MIN);
    localparam logic [10:0] XMX_C = 11'(X_MAX);
    localparam logic [10:0] LH_C  = 11'(LEVEL_H);
    localparam logic [10:0] HS_C  = 11'(H_STEP);
    localparam logic [7:0]  LAST_LEVEL_C = 8'(LEVELS - 1);
`ifdef BARREL_GRAVITY_EN
    localparam logic [10:0] VMX_C = 11'(V_MAX);
`else
    localparam logic [10:0] VS_C  = 11'(V_STEP);
`endif

    typedef enum logic [1:0] {S_IDLE, S_ROLL, S_FALL, S_EXIT} state_t;

    state_t      state_q, state_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic [10:0] target_q, target_d;
    logic [7:0]  level_q, level_d;
    logic        dir_q, dir_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
`ifdef BARREL_GRAVITY_EN
    logic [10:0] v_q, v_d;
`endif

    // Candidate positions for this tick. The headroom is compared before the
    // step is added, so neither axis can overshoot or wrap.
    logic [10:0] x_step, y_step, fall_step;
    logic        x_edge, y_land, last_level;

    // Motion arithmetic shared by the next-state and output logic
    always_comb begin
        x_step = xpos_q;
        x_edge = 1'b0;
        if (!dir_q) begin
            if (XMX_C - xpos_q <= HS_C) begin
                x_step = XMX_C;
                x_edge = 1'b1;
            end else begin
                x_step = xpos_q + HS_C;
            end
        end else begin
            if (xpos_q - XMN_C <= HS_C) begin
                x_step = XMN_C;
                x_edge = 1'b1;
            end else begin
                x_step = xpos_q - HS_C;
            end
        end
`ifdef BARREL_GRAVITY_EN
        fall_step = v_q;
`else
        fall_step = VS_C;
`endif
        y_land = 1'b0;
        if (target_q - ypos_q <= fall_step) begin
            y_step = target_q;
            y_land = 1'b1;
        end else begin
            y_step = ypos_q + fall_step;
        end
        last_level = (level_q == LAST_LEVEL_C);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            xpos_q   <= XS_C;
            ypos_q   <= YS_C;
            target_q <= YS_C;
            level_q  <= 8'd0;
            dir_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef BARREL_GRAVITY_EN
            v_q      <= 11'd1;
`endif
        end else begin
            state_q  <= state_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            target_q <= target_d;
            level_q  <= level_d;
            dir_q    <= dir_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef BARREL_GRAVITY_EN
            v_q      <= v_d;
`endif
        end
    end

    // Next state: clear overrides everything; motion only advances on tick
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_ROLL;
                S_ROLL: if (tick && x_edge) state_d = S_FALL;
                S_FALL: if (tick && y_land) state_d = last_level ? S_EXIT : S_ROLL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and flag updates for the registered outputs
    always_comb begin
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        target_d = target_q;
        level_d  = level_q;
        dir_d    = dir_q;
`ifdef BARREL_GRAVITY_EN
        v_d      = v_q;
`endif
        if (clear || (state_q == S_IDLE && start)) begin
            xpos_d  = XS_C;
            ypos_d  = YS_C;
            level_d = 8'd0;
            dir_d   = 1'b0;
        end else if (tick && state_q == S_ROLL) begin
            xpos_d = x_step;
            if (x_edge) begin
                target_d = ypos_q + LH_C;
`ifdef BARREL_GRAVITY_EN
                v_d      = 11'd1;
`endif
            end
        end else if (tick && state_q == S_FALL) begin
            ypos_d = y_step;
`ifdef BARREL_GRAVITY_EN
            v_d    = (v_q >= VMX_C) ? VMX_C : v_q + 11'd1;
`endif
            if (y_land) begin
                level_d = level_q + 8'd1;
                dir_d   = ~dir_q;
            end
        end
        active_d = (state_d == S_ROLL) || (state_d == S_FALL);
        done_d   = (state_d == S_EXIT);
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign dir    = dir_q;
    assign active = active_q;
    assign done   = done_q;

endmodule
